// File: rtl/neuron_buffer_loader_if.sv
// -----------------------------------------------------------------------------
// neuron_buffer_loader_if
//
// Bundles the signals of the neuron buffer loader: the load command, the
// incoming word stream and the write-side bus toward the neuron buffer.
//
// Signals
//   start       command strobe (host -> loader)
//   base_addr   first row address of the load (host -> loader)
//   word_count  number of words in the load (host -> loader)
//   s_data      stream word (host -> loader)
//   s_valid     stream word valid (host -> loader)
//   s_ready     loader accepts the word this cycle (loader -> host)
//   address     row address toward the buffer (loader -> buffer)
//   ioInputs    packed buffer I/O bus (loader -> buffer):
//                 [W+depth+1]          ioSelect
//                 [W+depth]            ioWrite
//                 [W+depth-1 -: depth] bank select
//                 [W-1:0]              data
//   busy        load in progress (loader -> host)
//   done        one-cycle completion pulse (loader -> host)
//
// Modports
//   master  host side: drives command and stream, observes everything else
//   slave   the loader itself
// -----------------------------------------------------------------------------
interface neuron_buffer_loader_if #(
  parameter int depth = 2,
  parameter int A     = 7,
  parameter int W     = 16,
  parameter int CW    = 16
);

  logic                 start;
  logic [A-1:0]         base_addr;
  logic [CW-1:0]        word_count;
  logic [W-1:0]         s_data;
  logic                 s_valid;
  logic                 s_ready;
  logic [A-1:0]         address;
  logic [W+depth+1:0]   ioInputs;
  logic                 busy;
  logic                 done;

  modport master (
    output start, base_addr, word_count, s_data, s_valid,
    input  s_ready, address, ioInputs, busy, done
  );

  modport slave (
    input  start, base_addr, word_count, s_data, s_valid,
    output s_ready, address, ioInputs, busy, done
  );

endinterface : neuron_buffer_loader_if

// File: rtl/neuron_buffer_loader.sv
// -----------------------------------------------------------------------------
// neuron_buffer_loader
//
// Write-side feeder for the neuron buffer. A load command (base row, word
// count) is taken in IDLE; the word stream is then accepted over a
// valid/ready handshake and each word is written to the buffer one cycle
// later, filling banks 0..D-1 of a row before moving to the next row. The
// row address is (base + row) modulo 2^A. ioSelect is held for the whole
// load and done pulses once at completion.
//
// Ports
//   CLK   rising-edge clock
//   RSTn  synchronous active-low reset
//   bus   neuron_buffer_loader_if.slave (command, stream, buffer bus,
//         busy/done)
//
// Build option
//   NEURON_LOADER_ZERO_PAD_EN  when defined, a load whose word count is not
//   a multiple of D is followed by zero writes to the remaining banks of the
//   final row (PAD state), so every touched row is fully written. When
//   undefined the unused banks of the final row are left untouched.
// -----------------------------------------------------------------------------
module neuron_buffer_loader #(
  parameter int depth = 2,
  parameter int A     = 7,
  parameter int W     = 16,
  parameter int CW    = 16
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  neuron_buffer_loader_if.slave bus
);

  localparam int D = 1 << depth;

`ifdef NEURON_LOADER_ZERO_PAD_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PAD  = 2'd2,
    S_DONE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd3
  } state_t;
`endif

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t          r_state;
  logic [A-1:0]    r_base;        // latched base row address
  logic [CW-1:0]   r_remaining;   // stream words still to be accepted
  logic [depth-1:0] r_bank;       // bank of the next write
  logic [A-1:0]    r_row;         // row offset of the next write

  // Registered bus outputs
  logic            r_io_select;
  logic            r_io_write;
  logic [depth-1:0] r_bank_sel;
  logic [W-1:0]    r_data;
  logic [A-1:0]    r_address;
  logic            r_busy;
  logic            r_done;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  state_t          w_state_next;
  logic            w_accept;      // command taken this cycle
  logic            w_xfer;        // stream word accepted this cycle
  logic            w_pad_write;   // zero word written this cycle
  logic            w_last_word;   // the accepted word is the final one
  logic [depth-1:0] w_bank_inc;
  logic [A-1:0]    w_row_inc;

  assign w_bank_inc  = r_bank + 1'b1;
  assign w_row_inc   = r_row + 1'b1;
  assign w_last_word = (r_remaining == CW'(1));

  // s_ready depends on state only, so it never combinationally loops back
  // through s_valid.
  assign bus.s_ready = (r_state == S_LOAD);

  // NOTE: every signal driven here is given a default before the case
  // statement, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_xfer       = 1'b0;
    w_pad_write  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept     = 1'b1;
          w_state_next = (bus.word_count == '0) ? S_DONE : S_LOAD;
        end
      end

      S_LOAD: begin
        w_xfer = bus.s_valid;
        if (w_xfer && w_last_word) begin
`ifdef NEURON_LOADER_ZERO_PAD_EN
          // A non-zero bank after this word means the final row is partial.
          w_state_next = (w_bank_inc != '0) ? S_PAD : S_DONE;
`else
          w_state_next = S_DONE;
`endif
        end
      end

`ifdef NEURON_LOADER_ZERO_PAD_EN
      S_PAD: begin
        w_pad_write = 1'b1;
        if (r_bank == '1) begin
          w_state_next = S_DONE;
        end
      end
`endif

      S_DONE: begin
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of block ordering.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_base      <= '0;
      r_remaining <= '0;
      r_bank      <= '0;
      r_row       <= '0;
      r_io_select <= 1'b0;
      r_io_write  <= 1'b0;
      r_bank_sel  <= '0;
      r_data      <= '0;
      r_address   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      // Write strobe and completion pulse last one cycle unless re-armed.
      r_io_write <= 1'b0;
      r_done     <= 1'b0;

      if (w_accept) begin
        r_base      <= bus.base_addr;
        r_remaining <= bus.word_count;
        r_bank      <= '0;
        r_row       <= '0;
        r_busy      <= 1'b1;
        // A zero-length load never selects the buffer.
        r_io_select <= (bus.word_count != '0);
      end

      if (w_xfer || w_pad_write) begin
        r_io_write <= 1'b1;
        r_bank_sel <= r_bank;
        r_data     <= w_xfer ? bus.s_data : '0;
        r_address  <= r_base + r_row;   // A-bit sum wraps modulo 2^A
        r_bank     <= w_bank_inc;
        if (r_bank == '1) begin
          r_row <= w_row_inc;
        end
      end

      if (w_xfer) begin
        r_remaining <= r_remaining - 1'b1;
      end

      // The cycle after DONE presents the completion: select and busy drop
      // together with the done pulse, one cycle after the last write.
      if (r_state == S_DONE) begin
        r_done      <= 1'b1;
        r_busy      <= 1'b0;
        r_io_select <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output mapping
  // ---------------------------------------------------------------------------
  assign bus.address  = r_address;
  assign bus.ioInputs = {r_io_select, r_io_write, r_bank_sel, r_data};
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

endmodule : neuron_buffer_loader

// File: tb/tb_neuron_buffer_loader.sv
// -----------------------------------------------------------------------------
// tb_neuron_buffer_loader
//
// Directed and randomized loads against a reference that lists the expected
// buffer writes (row, bank, data) directly from the base address, word count
// and word values, plus the expected done timing.
// -----------------------------------------------------------------------------
module tb_neuron_buffer_loader;

  localparam int DEPTH = 2;
  localparam int A     = 7;
  localparam int W     = 16;
  localparam int CW    = 16;
  localparam int D     = 1 << DEPTH;

  logic CLK = 1'b0;
  logic RSTn;

  always #5 CLK = ~CLK;

  neuron_buffer_loader_if #(.depth(DEPTH), .A(A), .W(W), .CW(CW)) bus ();

  neuron_buffer_loader #(.depth(DEPTH), .A(A), .W(W), .CW(CW)) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus)
  );

  typedef struct packed {
    logic [A-1:0]     addr;
    logic [DEPTH-1:0] bank;
    logic [W-1:0]     data;
  } wr_t;

  logic [W-1:0] words[$];
  wr_t          exp_q[$];
  wr_t          got_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: word i lands in row (base + i/D) mod 2^A, bank i mod D.
  // With zero padding the final row is completed with zero words.
  function automatic void build_model(input int base, input int cnt);
    int total;
    wr_t e;
    exp_q.delete();
    total = cnt;
`ifdef NEURON_LOADER_ZERO_PAD_EN
    total = ((cnt + D - 1) / D) * D;
`endif
    for (int i = 0; i < total; i++) begin
      e.addr = A'((base + i / D) % (1 << A));
      e.bank = DEPTH'(i % D);
      e.data = (i < cnt) ? words[i] : '0;
      exp_q.push_back(e);
    end
  endfunction

  // Issues one load and watches the bus cycle by cycle. Cycle k counts
  // sample points after the edge that accepted the command (k=1 first).
  //   stall_at/stall_len : hold s_valid low for stall_len ready cycles once
  //                        stall_at words have been accepted
  //   abort_at           : assert reset once abort_at words have been accepted
  //   glitch_at          : pulse start (other command) after glitch_at words
  //   rand_valid         : random s_valid gaps
  task automatic run_load(input string name, input int base, input int cnt,
                          input int stall_at, input int stall_len,
                          input int abort_at, input int glitch_at,
                          input bit rand_valid);
    int  idx, k, budget, stall_rem, done_k, first_k, last_k;
    int  gaps, sel_err, busy_n, extra;
    bit  valid, ready_now, sel, wr, aborted, glitched, exp_sel, done_seen;
    wr_t g;

    build_model(base, cnt);
    got_q.delete();
    idx = 0; k = 0; stall_rem = stall_len; done_k = -1; first_k = -1; last_k = -1;
    gaps = 0; sel_err = 0; busy_n = 0; extra = 0;
    aborted = 1'b0; glitched = 1'b0;
    budget = cnt * 8 + 40;

    bus.start      = 1'b1;
    bus.base_addr  = A'(base);
    bus.word_count = CW'(cnt);
    bus.s_valid    = 1'b0;
    @(posedge CLK); #1;
    bus.start = 1'b0;
    k = 1;

    while (k < budget) begin
      sel = bus.ioInputs[W+DEPTH+1];
      wr  = bus.ioInputs[W+DEPTH];
      if (wr) begin
        g.addr = bus.address;
        g.bank = bus.ioInputs[W+DEPTH-1 -: DEPTH];
        g.data = bus.ioInputs[W-1:0];
        got_q.push_back(g);
        if (first_k < 0) first_k = k;
        last_k = k;
      end else if (sel && first_k >= 0) begin
        gaps++;
      end
      exp_sel = bus.busy && (cnt != 0);
      if (sel !== exp_sel) sel_err++;
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_k = k;
        break;
      end

      bus.start = 1'b0;
      if (glitch_at >= 0 && idx == glitch_at && !glitched) begin
        glitched       = 1'b1;
        bus.start      = 1'b1;
        bus.base_addr  = A'(50);
        bus.word_count = CW'(1);
      end

      ready_now = bus.s_ready;
      if (abort_at >= 0 && idx == abort_at) begin
        bus.s_valid = 1'b0;
        RSTn = 1'b0;
        @(posedge CLK); #1;
        aborted = 1'b1;
        break;
      end

      valid = (idx < cnt);
      if (valid && idx == stall_at && stall_rem > 0) begin
        valid = 1'b0;
        if (ready_now) stall_rem--;
      end
      if (valid && rand_valid && ($urandom_range(3) == 0)) valid = 1'b0;
      bus.s_valid = valid;
      bus.s_data  = valid ? words[idx] : '0;

      @(posedge CLK); #1;
      if (valid && ready_now) idx++;
      k++;
    end
    bus.s_valid = 1'b0;
    bus.start   = 1'b0;

    if (aborted) begin
      check({name, " rst address"}, 64'(bus.address), 64'd0);
      check({name, " rst ioInputs"}, 64'(bus.ioInputs), 64'd0);
      check({name, " rst busy/done/ready"}, {bus.busy, bus.done, bus.s_ready}, 64'd0);
      check({name, " writes before reset"}, got_q.size(), abort_at);
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
        check($sformatf("%s wr%0d", name, i), 64'(got_q[i]), 64'(exp_q[i]));
      done_seen = 1'b0;
      @(posedge CLK); #1;
      if (bus.done) done_seen = 1'b1;
      RSTn = 1'b1;
      repeat (4) begin
        @(posedge CLK); #1;
        if (bus.done) done_seen = 1'b1;
      end
      check({name, " no done after reset"}, done_seen, 64'd0);
      return;
    end

    // Model-derived write list.
    check({name, " write count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s wr%0d", name, i), 64'(got_q[i]), 64'(exp_q[i]));

    // Timing: done directly after the last write (or 2 cycles after the
    // start edge for an empty load); busy through the cycle before done.
    if (cnt == 0) begin
      check({name, " done cycle"}, done_k, 2);
    end else begin
      check({name, " done after last write"}, done_k, last_k + 1);
    end
    if (!rand_valid)
      check({name, " done latency"}, done_k, exp_q.size() + 2 + stall_len);
    if (stall_len > 0)
      check({name, " stall gaps"}, gaps, stall_len);
    check({name, " busy cycles"}, busy_n, (done_k > 0) ? done_k - 1 : -1);
    check({name, " ioSelect tracks load"}, sel_err, 0);
    check({name, " s_ready at done"}, bus.s_ready, 1'b0);

    // Nothing may follow the completion (including an ignored start).
    repeat (3) begin
      @(posedge CLK); #1;
      if (bus.ioInputs[W+DEPTH] || bus.done || bus.busy) extra++;
    end
    check({name, " quiet after done"}, extra, 0);
  endtask

  task automatic fill_seq(input int cnt, input int first);
    words.delete();
    for (int i = 0; i < cnt; i++) words.push_back(W'(first + i));
  endtask

  task automatic fill_rand(input int cnt);
    words.delete();
    for (int i = 0; i < cnt; i++) words.push_back(W'($urandom));
  endtask

  initial begin
    int b, c;
    RSTn           = 1'b0;
    bus.start      = 1'b0;
    bus.base_addr  = '0;
    bus.word_count = '0;
    bus.s_data     = '0;
    bus.s_valid    = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset address", 64'(bus.address), 64'd0);
    check("reset ioInputs", 64'(bus.ioInputs), 64'd0);
    check("reset s_ready", bus.s_ready, 1'b0);
    check("reset busy", bus.busy, 1'b0);
    check("reset done", bus.done, 1'b0);
    RSTn = 1'b1;
    @(posedge CLK); #1;

    fill_seq(8, 1);
    run_load("continuous", 5, 8, -1, 0, -1, -1, 1'b0);

    fill_seq(8, 1);
    run_load("stall", 5, 8, 3, 2, -1, -1, 1'b0);

    words.delete();
    run_load("zero count", 9, 0, -1, 0, -1, -1, 1'b0);

    fill_seq(8, 16'h0100);
    run_load("addr wrap", 127, 8, -1, 0, -1, -1, 1'b0);

    fill_seq(6, 16'h000A);
    run_load("partial row", 20, 6, -1, 0, -1, -1, 1'b0);

    fill_seq(8, 16'h0200);
    run_load("abort", 40, 8, -1, 0, 3, -1, 1'b0);

    fill_seq(4, 16'h0300);
    run_load("reissue", 0, 4, -1, 0, -1, 2, 1'b0);

    for (int t = 0; t < 5; t++) begin
      b = $urandom_range(127);
      c = $urandom_range(13, 1);
      fill_rand(c);
      run_load($sformatf("random%0d", t), b, c, -1, 0, -1, -1, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_neuron_buffer_loader

// File: doc/neuron_buffer_loader.md
Name: neuron_buffer_loader

Overview:
- Upstream write-side feeder for the neuron buffer.
- Accepts a load command (base row address, word count) and a W-bit word stream over a valid/ready handshake.
- Serialises the words into the buffer's packed I/O control bus, filling banks 0..D-1 of one row before advancing to the next row.
- Drives the row address and holds I/O select for the whole load, then pulses done.

Parameters:
- depth, 2, log2 of bank count (convolutional unit size)
- A, 7, row address width of the buffer SRAM
- D, 1<<depth, number of banks per row (derived; not overridden)
- W, 16, data word width
- CW, 16, width of the word-count command field

Ports:
- CLK  input  1  clock; all logic on rising edge
- RSTn  input  1  synchronous active-low reset
- start  input  1  load command strobe; sampled only in IDLE
- base_addr  input  A  first row address of the load
- word_count  input  CW  number of W-bit words to write
- s_data  input  W  stream word
- s_valid  input  1  stream word valid
- s_ready  output  1  loader accepts word this cycle
- address  output  A  row address to the buffer
- ioInputs  output  W+depth+2  packed bus: [W+depth+1]=ioSelect, [W+depth]=ioWrite, [W+depth-1 -: depth]=bank select, [W-1:0]=data
- busy  output  1  high from start acceptance until done
- done  output  1  one-cycle pulse at load completion

Behaviour:
- Reset (RSTn=0 at a rising edge): state=IDLE. address, ioInputs, s_ready, busy and done are all 0. Internal bank and row counters are cleared.
- Reset mid-load aborts the load with no done pulse. Outputs are 0 from the following cycle. Words already written stay in the buffer.
- States: IDLE, LOAD, PAD (PAD only with the optional feature), DONE.
- IDLE:
  - start=1 latches base_addr and word_count, clears bank=0 and row=0, sets busy=1.
  - word_count!=0: next state LOAD.
  - word_count==0: next state DONE.
- start outside IDLE is ignored; command inputs are not re-sampled.
- LOAD:
  - s_ready=1 (combinational from state).
  - A transfer occurs when s_valid && s_ready.
  - On a transfer, the next cycle presents ioWrite=1, bank select=bank, data=s_data, and address=(base+row) mod 2^A. All of these are registered, so latency is 1 cycle.
  - Cycles without a transfer present ioWrite=0. ioSelect, address and bank select hold their previous values.
  - After each transfer, bank increments. At bank D-1, bank wraps to 0 and row increments. Row arithmetic is A bits and wraps modulo 2^A (row 2^A-1 is followed by row 0).
  - After the transfer that makes transfers equal word_count, s_ready drops next cycle and state goes to PAD (feature on, bank!=0 after increment) or DONE.
- ioSelect=1 for every cycle that busy=1 and state!=DONE, including stall cycles.
- DONE (1 cycle):
  - ioSelect=0, ioWrite=0, done=1, busy=0.
  - The last write is visible on the bus the cycle before done.
  - Next state IDLE.
- Transfer counter is CW bits. word_count up to 2^CW-1 is supported.
- No backpressure from the buffer: each presented write completes in one cycle.

Optional Feature:
- Macro: NEURON_LOADER_ZERO_PAD_EN.
- Defined:
  - When word_count is not a multiple of D, the loader enters PAD after the last stream word.
  - PAD writes data=0 to the remaining banks of the final row, one bank per cycle with ioWrite=1 and s_ready=0, then enters DONE.
  - Result: every touched row is fully written.
- Undefined:
  - The PAD state does not exist; unused banks of the final row are left unwritten.
  - The loader goes from LOAD directly to DONE.

Test Plan:
All cases use depth=2, W=16, A=7, CW=16.
- Continuous load: base=5, count=8, words 0x0001..0x0008 with s_valid held high.
  -> Writes (addr,bank,data): (5,0,1), (5,1,2), (5,2,3), (5,3,4), (6,0,5), …, (6,3,8) on 8 consecutive cycles.
  -> done pulses 1 cycle after the last write; ioSelect then 0.
- Stalls: same load with s_valid low for 2 cycles after word 3.
  -> ioWrite=0 for exactly 2 cycles while ioSelect stays 1.
  -> Write sequence is identical to the continuous case; done is 2 cycles later.
- Zero count: start with count=0.
  -> No ioWrite.
  -> done=1 exactly 2 cycles after the start edge (IDLE→DONE→IDLE); busy is high for 1 cycle.
- Address wrap: base=127, count=8.
  -> Rows 127 then 0, four writes each.
- Partial row: count=6, words 0xA..0xF.
  -> Feature on: additional writes (base+1,2,0x0000) and (base+1,3,0x0000) before done.
  -> Feature off: exactly 6 writes, then done.
- Reset and re-issue: assert RSTn=0 after 3 transfers.
  -> Next cycle all outputs are 0 and no done pulse.
  -> A new start (base=0, count=4) writes banks 0..3 of row 0 starting at bank 0.
  -> A start asserted during LOAD is ignored.
